if_stage: RTL and testbench

Instruction-fetch stage sitting directly upstream of `ID_Stage`. It owns the program counter and fetches one 32-bit instruction at a time over a valid/ready instruction-memory port. It presents the instruction to decode and holds it until decode consumes it. On consume, it computes the next PC from the decode/execute control (`Branch`, `Jal`, `Jalr`, branch outcome, `ImmExt`, `RD1`).

---
 rtl/if_pkg.sv | 15 +
 rtl/next_pc_unit.sv | 31 +++
 rtl/if_stage.sv | 96 +++++++++
 tb/tb_if_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } if_state_e;

    localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

endpackage

// File: rtl/next_pc_unit.sv
// Next-PC select (jalr > jal/taken branch > sequential) and target misalignment detect.
module next_pc_unit
    import if_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            branch,
    input  logic            branch_taken,
    input  logic            jal,
    input  logic            jalr,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] next_pc_c,
    output logic            misaligned_c
);

    logic [XLEN-1:0] jalr_sum;

    assign jalr_sum = rd1 + imm_ext;

    always_comb begin
        next_pc_c = pc + XLEN'(4);
        if (jalr) begin
            next_pc_c = jalr_sum & ~XLEN'(1);
        end else if (jal || (branch && branch_taken)) begin
            next_pc_c = pc + imm_ext;
        end
    end

    assign misaligned_c = (next_pc_c[1:0] != 2'b00);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a valid/ready port, holds the word for decode.
// Optional feature: IF_MISALIGN_TRAP_EN redirects misaligned targets to TRAP_VEC_DEFAULT.
module if_stage
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            Stall,
    input  logic            Branch,
    input  logic            Jal,
    input  logic            Jalr,
    input  logic            BranchTaken,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] Instr,
    output logic            InstrValid,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            InstrMisaligned
);

    if_state_e       state;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    next_pc_unit u_next_pc (
        .pc           (PC),
        .branch       (Branch),
        .branch_taken (BranchTaken),
        .jal          (Jal),
        .jalr         (Jalr),
        .imm_ext      (ImmExt),
        .rd1          (RD1),
        .next_pc_c    (next_pc),
        .misaligned_c (misaligned)
    );

    assign imem_req  = (state == REQ);
    assign imem_addr = PC;
    assign PCPlus4   = PC + XLEN'(4);

`ifdef IF_MISALIGN_TRAP_EN
    logic misaligned_q;
    assign InstrMisaligned = misaligned_q;
`else
    assign InstrMisaligned = 1'b0;
`endif

    // Control inputs only matter on the consume edge (HOLD with Stall low).
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= REQ;
            PC         <= RESET_PC;
            Instr      <= NOP;
            InstrValid <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            case (state)
                REQ: begin
                    if (imem_ready) begin
                        Instr      <= imem_rdata;
                        InstrValid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        Instr      <= NOP;
                        InstrValid <= 1'b0;
                        state      <= REQ;
`ifdef IF_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            PC           <= TRAP_VEC_DEFAULT;
                            misaligned_q <= 1'b1;
                        end else begin
                            PC <= next_pc;
                        end
`else
                        PC <= misaligned ? {next_pc[XLEN-1:2], 2'b00} : next_pc;
`endif
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; expectations follow IF_MISALIGN_TRAP_EN when defined.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        Stall, Branch, Jal, Jalr, BranchTaken;
    logic [31:0] ImmExt, RD1;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC, PCPlus4;
    logic        InstrMisaligned;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory model: a fixed word at 0, an address-tagged word elsewhere.
    assign imem_rdata = (imem_addr == 32'h0) ? 32'h0050_0093 : {8'hA5, imem_addr[23:0]};

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .Stall           (Stall),
        .Branch          (Branch),
        .Jal             (Jal),
        .Jalr            (Jalr),
        .BranchTaken     (BranchTaken),
        .ImmExt          (ImmExt),
        .RD1             (RD1),
        .Instr           (Instr),
        .InstrValid      (InstrValid),
        .PC              (PC),
        .PCPlus4         (PCPlus4),
        .InstrMisaligned (InstrMisaligned)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctrl();
        Branch = 1'b0; BranchTaken = 1'b0; Jal = 1'b0; Jalr = 1'b0;
        ImmExt = 32'h0; RD1 = 32'h0;
    endtask

    // Consume the held instruction with the given control, then drop the control.
    task automatic consume(input logic br, input logic bt, input logic j, input logic jr,
                           input logic [31:0] imm, input logic [31:0] rs1);
        Branch = br; BranchTaken = bt; Jal = j; Jalr = jr; ImmExt = imm; RD1 = rs1;
        Stall = 1'b0;
        tick();
        clear_ctrl();
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; Stall = 1'b0;
        clear_ctrl();
        tick();
        tick();
        check("rst_valid", 32'(InstrValid), 32'h0);
        check("rst_instr", Instr, 32'h0000_0013);
        check("rst_pc", PC, 32'h0);
        check("rst_mis", 32'(InstrMisaligned), 32'h0);
        check("rst_req", 32'(imem_req), 32'h1);

        // Ready during reset must be discarded.
        imem_ready = 1'b1;
        tick();
        check("rst_ready_nocap", 32'(InstrValid), 32'h0);

        reset = 1'b0;
        check("c0_req", 32'(imem_req), 32'h1);
        check("c0_addr", imem_addr, 32'h0);
        tick();
        check("c1_valid", 32'(InstrValid), 32'h1);
        check("c1_instr", Instr, 32'h0050_0093);
        check("c1_pc", PC, 32'h0);
        check("c1_pc4", PCPlus4, 32'h4);
        check("c1_noreq", 32'(imem_req), 32'h0);
        imem_ready = 1'b0;
        tick();
        check("seq_addr", imem_addr, 32'h4);
        check("seq_invalid", 32'(InstrValid), 32'h0);
        check("seq_nop", Instr, 32'h0000_0013);

        // Three wait cycles: request and address hold for four cycles.
        for (int i = 0; i < 3; i++) begin
            check("wait_req", 32'(imem_req), 32'h1);
            check("wait_addr", imem_addr, 32'h4);
            check("wait_valid", 32'(InstrValid), 32'h0);
            tick();
        end
        check("wait_req4", 32'(imem_req), 32'h1);
        check("wait_addr4", imem_addr, 32'h4);
        imem_ready = 1'b1;
        Stall = 1'b1;
        tick();
        check("wait_valid_after", 32'(InstrValid), 32'h1);
        check("wait_instr", Instr, 32'hA500_0004);

        // Stall holds everything in HOLD; no request.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_instr", Instr, 32'hA500_0004);
            check("stall_pc", PC, 32'h4);
            check("stall_noreq", 32'(imem_req), 32'h0);
            check("stall_valid", 32'(InstrValid), 32'h1);
        end
        consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("stall_release_addr", imem_addr, 32'h8);

        // Stall is ignored in REQ.
        Stall = 1'b1;
        tick();
        check("req_stall_cap", 32'(InstrValid), 32'h1);
        check("req_stall_pc", PC, 32'h8);
        consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("addr_c", imem_addr, 32'hC);
        tick();
        consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("addr_10", imem_addr, 32'h10);

        // Taken branch backwards.
        tick();
        check("br_pc", PC, 32'h10);
        consume(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
        check("br_taken_addr", imem_addr, 32'h8);

        // Back to 0x10 with jal +8, then a not-taken branch.
        tick();
        consume(1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
        check("jal_addr", imem_addr, 32'h10);
        tick();
        consume(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
        check("br_nt_addr", imem_addr, 32'h14);

        // Jalr wins over jal and clears bit 0.
        tick();
        consume(1'b0, 1'b0, 1'b1, 1'b1, 32'h4, 32'h101);
        check("jalr_addr", imem_addr, 32'h104);

        // Return to 0, then jal to a misaligned target.
        tick();
        consume(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        check("jalr0_addr", imem_addr, 32'h0);
        tick();
        consume(1'b0, 1'b0, 1'b1, 1'b0, 32'h6, 32'h0);
`ifdef IF_MISALIGN_TRAP_EN
        check("mis_addr", imem_addr, 32'h100);
        check("mis_flag", 32'(InstrMisaligned), 32'h1);
`else
        check("mis_addr", imem_addr, 32'h4);
        check("mis_flag", 32'(InstrMisaligned), 32'h0);
`endif

        // Wrap from 0xFFFF_FFFC to 0.
        tick();
        consume(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_instr", Instr, 32'hA5FF_FFFC);
        check("wrap_pc4", PCPlus4, 32'h0);
        consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("wrap_next", imem_addr, 32'h0);
`ifdef IF_MISALIGN_TRAP_EN
        check("mis_sticky", 32'(InstrMisaligned), 32'h1);
`endif

        // Advance off RESET_PC, then reset with ready high in REQ.
        tick();
        consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("pre_rst_addr", imem_addr, 32'h4);
        reset = 1'b1;
        tick();
        check("rst2_pc", PC, 32'h0);
        check("rst2_valid", 32'(InstrValid), 32'h0);
        check("rst2_instr", Instr, 32'h0000_0013);
        check("rst2_mis", 32'(InstrMisaligned), 32'h0);
        reset = 1'b0;
        imem_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
